// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: pipeline backward-control bundle between the stage logic and pipe_ctrl.
//   Requests toward the controller: stallreq_if/id/ex/mem, ex_branch_flag, ex_branch_target,
//   if_redirect_ready.
//   Controls back to the stages: stall[5:0] (PC, if_id, id_ex, ex_mem, mem_wb, reserved),
//   flush_if_id, flush_id_ex, redirect_valid, redirect_pc, perf_stall_cycles, perf_redirects.
//   master = pipeline side, slave = pipe_ctrl side.
interface pipe_ctrl_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int CNT_WIDTH  = 32
);
    logic                  stallreq_if;
    logic                  stallreq_id;
    logic                  stallreq_ex;
    logic                  stallreq_mem;
    logic                  ex_branch_flag;
    logic [ADDR_WIDTH-1:0] ex_branch_target;
    logic                  if_redirect_ready;
    logic [5:0]            stall;
    logic                  flush_if_id;
    logic                  flush_id_ex;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [CNT_WIDTH-1:0]  perf_stall_cycles;
    logic [CNT_WIDTH-1:0]  perf_redirects;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output ex_branch_flag, ex_branch_target, if_redirect_ready,
        input  stall, flush_if_id, flush_id_ex, redirect_valid, redirect_pc,
        input  perf_stall_cycles, perf_redirects
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  ex_branch_flag, ex_branch_target, if_redirect_ready,
        output stall, flush_if_id, flush_id_ex, redirect_valid, redirect_pc,
        output perf_stall_cycles, perf_redirects
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline stall/flush control with branch redirect FSM and debug counters.
//   clk  : system clock, all state on posedge
//   rst  : asynchronous active-low reset (0 = reset)
//   bus  : pipe_ctrl_if.slave -- stall requests and EX branch resolution in; stall vector,
//          flushes, redirect_valid/redirect_pc handshake and saturating perf counters out.
module pipe_ctrl #(
    parameter int ADDR_WIDTH = 17,
    parameter int CNT_WIDTH  = 32
) (
    input logic       clk,
    input logic       rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic {IDLE, REDIRECT} state_t;

    state_t                state;
    logic                  accept;
    logic [5:0]            stall;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic [CNT_WIDTH-1:0]  stall_cnt;
    logic [CNT_WIDTH-1:0]  redir_cnt;

    // Deepest requesting stage wins; everything upstream of it holds too. Gated by rst so the
    // combinational outputs read as zero while reset is asserted.
    always_comb begin
        stall = !rst            ? 6'b000000 :
                bus.stallreq_mem ? 6'b011111 :
                bus.stallreq_ex  ? 6'b001111 :
                bus.stallreq_id  ? 6'b000111 :
                bus.stallreq_if  ? 6'b000011 : 6'b000000;
    end

    // A branch held up by a busy EX/MEM is simply not taken yet; EX re-presents it when free.
    assign accept = rst && state == IDLE && bus.ex_branch_flag && !bus.stallreq_ex && !bus.stallreq_mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            stall_cnt      <= '0;
            redir_cnt      <= '0;
        end else begin
            if (accept) begin
                state          <= REDIRECT;
                redirect_valid <= 1'b1;
                redirect_pc    <= bus.ex_branch_target;
            end else if (state == REDIRECT && redirect_valid && bus.if_redirect_ready) begin
                state          <= IDLE;
                redirect_valid <= 1'b0;
            end
            if (stall != 6'b000000 && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (accept && redir_cnt != '1)
                redir_cnt <= redir_cnt + 1'b1;
        end
    end

    // Flushes cover the accept cycle itself and every cycle the redirect is outstanding.
    assign bus.flush_if_id       = accept || state == REDIRECT;
    assign bus.flush_id_ex       = accept || state == REDIRECT;
    assign bus.stall             = stall;
    assign bus.redirect_valid    = redirect_valid;
    assign bus.redirect_pc       = redirect_pc;
    assign bus.perf_stall_cycles = stall_cnt;
    assign bus.perf_redirects    = redir_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl (32-bit and 4-bit counter instances).
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.ADDR_WIDTH(17), .CNT_WIDTH(32)) bm ();
    pipe_ctrl_if #(.ADDR_WIDTH(17), .CNT_WIDTH(4))  bs ();

    assign bs.stallreq_if       = bm.stallreq_if;
    assign bs.stallreq_id       = bm.stallreq_id;
    assign bs.stallreq_ex       = bm.stallreq_ex;
    assign bs.stallreq_mem      = bm.stallreq_mem;
    assign bs.ex_branch_flag    = bm.ex_branch_flag;
    assign bs.ex_branch_target  = bm.ex_branch_target;
    assign bs.if_redirect_ready = bm.if_redirect_ready;

    pipe_ctrl #(.ADDR_WIDTH(17), .CNT_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bm));
    pipe_ctrl #(.ADDR_WIDTH(17), .CNT_WIDTH(4))  dut_small (.clk(clk), .rst(rst), .bus(bs));

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bm.stallreq_if = 0; bm.stallreq_id = 0; bm.stallreq_ex = 0; bm.stallreq_mem = 0;
        bm.ex_branch_flag = 0; bm.ex_branch_target = '0; bm.if_redirect_ready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        tick();
        checks++; if (bm.redirect_valid !== 1'b0 || bm.stall !== 6'd0 || bm.flush_if_id !== 1'b0) begin
            errors++; $display("FAIL reset_init valid=%b stall=%b flush=%b exp 0", bm.redirect_valid, bm.stall, bm.flush_if_id); end
        rst = 1;
        tick();
        bm.ex_branch_flag = 1; bm.ex_branch_target = 17'h00ABC;
        tick();
        bm.ex_branch_flag = 0;
        #1;
        checks++; if (bm.redirect_valid !== 1'b1 || bm.redirect_pc !== 17'h00ABC) begin
            errors++; $display("FAIL reset_pre_redirect valid=%b pc=%h exp 1/00abc", bm.redirect_valid, bm.redirect_pc); end
        rst = 0;
        #1;
        checks++; if (bm.redirect_valid !== 1'b0 || bm.redirect_pc !== 17'h0 || bm.flush_if_id !== 1'b0 ||
                      bm.flush_id_ex !== 1'b0 || bm.perf_redirects !== 32'd0 || bm.perf_stall_cycles !== 32'd0) begin
            errors++; $display("FAIL reset_async valid=%b pc=%h fl=%b%b redir=%0d stallc=%0d exp all 0",
                bm.redirect_valid, bm.redirect_pc, bm.flush_if_id, bm.flush_id_ex, bm.perf_redirects, bm.perf_stall_cycles); end
        tick();
        rst = 1;
        bm.if_redirect_ready = 1;
        tick();
        checks++; if (bm.redirect_valid !== 1'b0 || bm.flush_if_id !== 1'b0 || bm.flush_id_ex !== 1'b0) begin
            errors++; $display("FAIL reset_idle valid=%b fl=%b%b exp 0/00", bm.redirect_valid, bm.flush_if_id, bm.flush_id_ex); end
        bm.if_redirect_ready = 0;
    endtask

    task automatic test_stall_priority();
        bm.stallreq_if = 1; bm.stallreq_mem = 1;
        #1;
        checks++; if (bm.stall !== 6'b011111) begin errors++; $display("FAIL stall_if_mem got=%b exp=011111", bm.stall); end
        tick();
        bm.stallreq_if = 0; bm.stallreq_mem = 0; bm.stallreq_id = 1;
        #1;
        checks++; if (bm.stall !== 6'b000111) begin errors++; $display("FAIL stall_id got=%b exp=000111", bm.stall); end
        tick();
        bm.stallreq_id = 0; bm.stallreq_ex = 1; bm.stallreq_if = 1;
        #1;
        checks++; if (bm.stall !== 6'b001111) begin errors++; $display("FAIL stall_ex got=%b exp=001111", bm.stall); end
        tick();
        bm.stallreq_ex = 0;
        #1;
        checks++; if (bm.stall !== 6'b000011) begin errors++; $display("FAIL stall_if got=%b exp=000011", bm.stall); end
        tick();
        bm.stallreq_if = 0;
        #1;
        checks++; if (bm.stall !== 6'b000000) begin errors++; $display("FAIL stall_none got=%b exp=000000", bm.stall); end
        tick();
        checks++; if (bm.perf_stall_cycles !== 32'd4) begin errors++; $display("FAIL stall_count got=%0d exp=4", bm.perf_stall_cycles); end
    endtask

    task automatic test_branch();
        bm.ex_branch_flag = 1; bm.ex_branch_target = 17'h01234;
        #1;
        checks++; if (bm.flush_if_id !== 1'b1 || bm.flush_id_ex !== 1'b1 || bm.redirect_valid !== 1'b0) begin
            errors++; $display("FAIL branch_accept fl=%b%b valid=%b exp 11/0", bm.flush_if_id, bm.flush_id_ex, bm.redirect_valid); end
        tick();
        bm.ex_branch_flag = 0; bm.if_redirect_ready = 1;
        #1;
        checks++; if (bm.flush_if_id !== 1'b1 || bm.flush_id_ex !== 1'b1 || bm.redirect_valid !== 1'b1 ||
                      bm.redirect_pc !== 17'h01234 || bm.perf_redirects !== 32'd1) begin
            errors++; $display("FAIL branch_redirect fl=%b%b valid=%b pc=%h redir=%0d exp 11/1/01234/1",
                bm.flush_if_id, bm.flush_id_ex, bm.redirect_valid, bm.redirect_pc, bm.perf_redirects); end
        tick();
        bm.if_redirect_ready = 0;
        #1;
        checks++; if (bm.flush_if_id !== 1'b0 || bm.flush_id_ex !== 1'b0 || bm.redirect_valid !== 1'b0) begin
            errors++; $display("FAIL branch_done fl=%b%b valid=%b exp 00/0", bm.flush_if_id, bm.flush_id_ex, bm.redirect_valid); end
    endtask

    task automatic test_branch_stalled();
        bm.ex_branch_flag = 1; bm.ex_branch_target = 17'h00555; bm.stallreq_ex = 1;
        #1;
        checks++; if (bm.flush_if_id !== 1'b0 || bm.stall !== 6'b001111) begin
            errors++; $display("FAIL bstall_hold fl=%b stall=%b exp 0/001111", bm.flush_if_id, bm.stall); end
        tick();
        checks++; if (bm.redirect_valid !== 1'b0 || bm.perf_redirects !== 32'd1) begin
            errors++; $display("FAIL bstall_noredir valid=%b redir=%0d exp 0/1", bm.redirect_valid, bm.perf_redirects); end
        bm.stallreq_ex = 0;
        #1;
        checks++; if (bm.flush_id_ex !== 1'b1) begin errors++; $display("FAIL bstall_accept fl=%b exp 1", bm.flush_id_ex); end
        tick();
        bm.ex_branch_flag = 0; bm.if_redirect_ready = 1;
        checks++; if (bm.redirect_valid !== 1'b1 || bm.redirect_pc !== 17'h00555 || bm.perf_redirects !== 32'd2) begin
            errors++; $display("FAIL bstall_redirect valid=%b pc=%h redir=%0d exp 1/00555/2", bm.redirect_valid, bm.redirect_pc, bm.perf_redirects); end
        tick();
        bm.if_redirect_ready = 0;
    endtask

    task automatic test_redirect_hold();
        bm.ex_branch_flag = 1; bm.ex_branch_target = 17'h01234;
        tick();
        for (int i = 0; i < 3; i++) begin
            bm.ex_branch_flag = 1; bm.ex_branch_target = 17'h0FFFF; bm.if_redirect_ready = 0;
            #1;
            checks++; if (bm.redirect_valid !== 1'b1 || bm.redirect_pc !== 17'h01234 || bm.flush_if_id !== 1'b1 || bm.flush_id_ex !== 1'b1) begin
                errors++; $display("FAIL hold_%0d valid=%b pc=%h fl=%b%b exp 1/01234/11", i, bm.redirect_valid, bm.redirect_pc, bm.flush_if_id, bm.flush_id_ex); end
            tick();
        end
        // stall[0] set during the handshake must not block it
        bm.ex_branch_flag = 0; bm.if_redirect_ready = 1; bm.stallreq_if = 1;
        tick();
        bm.if_redirect_ready = 0; bm.stallreq_if = 0;
        #1;
        checks++; if (bm.redirect_valid !== 1'b0 || bm.perf_redirects !== 32'd3 || bm.flush_if_id !== 1'b0) begin
            errors++; $display("FAIL hold_release valid=%b redir=%0d fl=%b exp 0/3/0", bm.redirect_valid, bm.perf_redirects, bm.flush_if_id); end
    endtask

    task automatic test_back_to_back();
        bm.ex_branch_flag = 1; bm.ex_branch_target = 17'h00100;
        tick();
        bm.ex_branch_target = 17'h00200; bm.if_redirect_ready = 1;
        tick();
        // back in IDLE with the flag still high: the new branch is accepted right away
        #1;
        checks++; if (bm.flush_if_id !== 1'b1 || bm.redirect_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_accept fl=%b valid=%b exp 1/0", bm.flush_if_id, bm.redirect_valid); end
        tick();
        bm.ex_branch_flag = 0;
        checks++; if (bm.redirect_valid !== 1'b1 || bm.redirect_pc !== 17'h00200 || bm.perf_redirects !== 32'd5) begin
            errors++; $display("FAIL b2b_second valid=%b pc=%h redir=%0d exp 1/00200/5", bm.redirect_valid, bm.redirect_pc, bm.perf_redirects); end
        tick();
        bm.if_redirect_ready = 0;
    endtask

    task automatic test_counter_saturation();
        bm.stallreq_mem = 1;
        repeat (20) tick();
        bm.stallreq_mem = 0;
        tick();
        checks++; if (bs.perf_stall_cycles !== 4'hF) begin errors++; $display("FAIL sat_small got=%h exp=f", bs.perf_stall_cycles); end
        checks++; if (bm.perf_stall_cycles !== 32'd26) begin errors++; $display("FAIL sat_big got=%0d exp=26", bm.perf_stall_cycles); end
        checks++; if (bs.perf_redirects !== 4'd5) begin errors++; $display("FAIL sat_redir_small got=%0d exp=5", bs.perf_redirects); end
    endtask

    initial begin
        test_reset();
        test_stall_priority();
        test_branch();
        test_branch_stalled();
        test_redirect_hold();
        test_back_to_back();
        test_counter_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
